// File: rtl/msg_sender2_pkg.sv
// Shared definitions for the message sender and its header byte mux.
//   HEADER_BYTES : number of header bytes preceding the data payload
//   DEFAULT_SYNC : default sync word, first field of every header
//   state_t      : sender FSM state encoding
package msg_sender2_pkg;

  localparam int          HEADER_BYTES = 8;
  localparam logic [15:0] DEFAULT_SYNC = 16'h1234;

  typedef enum logic [2:0] {
    Idle    = 3'd0,
    Prep    = 3'd1,
    WaitRdy = 3'd2,
    Load    = 3'd3,
    Gap     = 3'd4,
    DoneSt  = 3'd5
  } state_t;

endpackage

// File: rtl/msg_sender2_hdr_mux.sv
// MsgHeaderMux: combinational selection of one header byte.
// Header layout (each 16-bit field LSB first):
//   0-1 sync, 2-3 message id, 4-5 byte count, 6-7 sequence number
// Ports:
//   index     in  3  header byte index 0-7
//   sync      in 16  sync word
//   msgId     in 16  message id
//   byteCount in 16  total byte count (header + data)
//   seqNum    in 16  sequence number
//   hdrByte   out 8  selected header byte
module MsgHeaderMux
  import msg_sender2_pkg::*;
(
  input  logic [2:0]  index,
  input  logic [15:0] sync,
  input  logic [15:0] msgId,
  input  logic [15:0] byteCount,
  input  logic [15:0] seqNum,
  output logic [7:0]  hdrByte
);

  always_comb begin
    hdrByte = 8'h00;
    case (index)
      3'd0: hdrByte = sync[7:0];
      3'd1: hdrByte = sync[15:8];
      3'd2: hdrByte = msgId[7:0];
      3'd3: hdrByte = msgId[15:8];
      3'd4: hdrByte = byteCount[7:0];
      3'd5: hdrByte = byteCount[15:8];
      3'd6: hdrByte = seqNum[7:0];
      3'd7: hdrByte = seqNum[15:8];
      default: hdrByte = 8'h00;
    endcase
  end

endmodule

// File: rtl/msg_sender2.sv
// msg_sender2: sends one of two fixed-format messages byte by byte to a
// parallel-to-serial converter. Each message is an 8-byte header followed
// by LENn bytes read sequentially from data RAM n.
// Ports:
//   Clock                in  clock, all logic on posedge
//   Clear                in  synchronous active-high reset
//   Send1/Send2          in  transmit requests, only honoured in Idle
//   Busy                 out high whenever not Idle
//   Done                 out one-cycle pulse after the last byte is loaded
//   TxByte/TxLoad        out byte and its load strobe to the serializer
//   TxReady              in  serializer can accept a byte
//   ClearMsg1/ClearMsg2  out reset data RAM n read address
//   ReadMsg1/ReadMsg2    out advance data RAM n read address
//   DataByte1/DataByte2  in  data RAM n output (1 cycle after a strobe)
module msg_sender2
  import msg_sender2_pkg::*;
#(
  parameter logic [15:0] SYNC = DEFAULT_SYNC,
  parameter logic [15:0] ID1  = 16'd101,
  parameter logic [15:0] ID2  = 16'd102,
  parameter logic [15:0] LEN1 = 16'd16,
  parameter logic [15:0] LEN2 = 16'd16
) (
  input  logic       Clock,
  input  logic       Clear,
  input  logic       Send1,
  input  logic       Send2,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] TxByte,
  output logic       TxLoad,
  input  logic       TxReady,
  output logic       ClearMsg1,
  output logic       ClearMsg2,
  output logic       ReadMsg1,
  output logic       ReadMsg2,
  input  logic [7:0] DataByte1,
  input  logic [7:0] DataByte2
);

  state_t      state, nextState;
  logic        sel;        // 0 = message 1, 1 = message 2
  logic [16:0] idx;        // 17 bits so 8+LEN never overflows
  logic [15:0] seqNum;

  logic [16:0] lenSel;
  logic [16:0] lastIdx;
  logic [15:0] byteCount;
  logic [15:0] msgId;
  logic        isData;
  logic [7:0]  hdrByte;
  logic [7:0]  dataByte;

  assign lenSel    = {1'b0, (sel ? LEN2 : LEN1)};
  assign lastIdx   = lenSel + 17'(HEADER_BYTES - 1);
  assign byteCount = lenSel[15:0] + 16'(HEADER_BYTES);  // wraps mod 2^16
  assign msgId     = sel ? ID2 : ID1;
  assign isData    = (idx >= 17'(HEADER_BYTES));
  assign dataByte  = sel ? DataByte2 : DataByte1;

  MsgHeaderMux uHdrMux (
    .index    (idx[2:0]),
    .sync     (SYNC),
    .msgId    (msgId),
    .byteCount(byteCount),
    .seqNum   (seqNum),
    .hdrByte  (hdrByte)
  );

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state  <= Idle;
      sel    <= 1'b0;
      idx    <= '0;
      seqNum <= '0;
    end else begin
      state <= nextState;
      case (state)
        Idle:    if (Send1) sel <= 1'b0;
                 else if (Send2) sel <= 1'b1;
        Prep:    idx <= '0;
        Gap:     idx <= idx + 17'd1;
        DoneSt:  seqNum <= seqNum + 16'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    nextState = state;
    Busy      = (state != Idle);
    Done      = 1'b0;
    TxLoad    = 1'b0;
    TxByte    = 8'h00;
    ClearMsg1 = 1'b0;
    ClearMsg2 = 1'b0;
    ReadMsg1  = 1'b0;
    ReadMsg2  = 1'b0;
    case (state)
      Idle:    if (Send1 || Send2) nextState = Prep;
      Prep: begin
        ClearMsg1 = ~sel;
        ClearMsg2 = sel;
        nextState = WaitRdy;
      end
      WaitRdy: if (TxReady) nextState = Load;
      Load: begin
        TxLoad = 1'b1;
        TxByte = isData ? dataByte : hdrByte;
        // Advance the RAM address as its byte is consumed so the next one
        // is valid by the following Load.
        ReadMsg1  = isData & ~sel;
        ReadMsg2  = isData & sel;
        nextState = Gap;
      end
      Gap:     nextState = (idx == lastIdx) ? DoneSt : WaitRdy;
      DoneSt: begin
        Done      = 1'b1;
        nextState = Idle;
      end
      default: nextState = Idle;
    endcase
  end

endmodule

// File: tb/tb_msg_sender2.sv
module tb_msg_sender2;

  logic       Clock = 1'b0;
  logic       Clear, Send1, Send2, TxReady;
  logic       Busy, Done, TxLoad;
  logic [7:0] TxByte, DataByte1, DataByte2;
  logic       ClearMsg1, ClearMsg2, ReadMsg1, ReadMsg2;

  always #5 Clock = ~Clock;

  msg_sender2 #(.LEN1(16'd2), .LEN2(16'd0)) dut (
    .Clock(Clock), .Clear(Clear), .Send1(Send1), .Send2(Send2),
    .Busy(Busy), .Done(Done), .TxByte(TxByte), .TxLoad(TxLoad),
    .TxReady(TxReady), .ClearMsg1(ClearMsg1), .ClearMsg2(ClearMsg2),
    .ReadMsg1(ReadMsg1), .ReadMsg2(ReadMsg2),
    .DataByte1(DataByte1), .DataByte2(DataByte2)
  );

  // data RAM models
  logic [7:0] mem1 [4];
  logic [7:0] mem2 [4];
  logic [1:0] a1 = 2'd0, a2 = 2'd0;
  initial begin
    mem1[0] = 8'hAA; mem1[1] = 8'hBB; mem1[2] = 8'hCC; mem1[3] = 8'hDD;
    mem2[0] = 8'h11; mem2[1] = 8'h22; mem2[2] = 8'h33; mem2[3] = 8'h44;
  end
  always @(posedge Clock) begin
    if (ClearMsg1) a1 <= 2'd0; else if (ReadMsg1) a1 <= a1 + 2'd1;
    if (ClearMsg2) a2 <= 2'd0; else if (ReadMsg2) a2 <= a2 + 2'd1;
  end
  assign DataByte1 = mem1[a1];
  assign DataByte2 = mem2[a2];

  int nCmp = 0, nErr = 0;
  logic [7:0] exp [$];
  int loadCnt = 0, cl1 = 0, cl2 = 0, rd1 = 0, rd2 = 0, doneCnt = 0;
  logic [15:0] seqModel = 16'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nCmp++;
    if (act !== req) begin
      nErr++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // scoreboard / strobe monitor
  always @(negedge Clock) begin
    if (TxLoad) begin
      loadCnt++;
      if (exp.size() == 0) chk("unexpected_txload", {24'h0, TxByte}, 32'hFFFF_FFFF);
      else chk($sformatf("txbyte_%0d", loadCnt), {24'h0, TxByte}, {24'h0, exp.pop_front()});
    end
    cl1 += int'(ClearMsg1); cl2 += int'(ClearMsg2);
    rd1 += int'(ReadMsg1);  rd2 += int'(ReadMsg2);
    doneCnt += int'(Done);
  end

  task automatic step();
    @(negedge Clock); #1;
  endtask

  task automatic pushMsg(input int sel);
    logic [15:0] id, bc;
    id = (sel == 1) ? 16'd101 : 16'd102;
    bc = (sel == 1) ? 16'd10 : 16'd8;
    exp.push_back(8'h34); exp.push_back(8'h12);
    exp.push_back(id[7:0]); exp.push_back(id[15:8]);
    exp.push_back(bc[7:0]); exp.push_back(bc[15:8]);
    exp.push_back(seqModel[7:0]); exp.push_back(seqModel[15:8]);
    if (sel == 1) begin exp.push_back(8'hAA); exp.push_back(8'hBB); end
    seqModel = seqModel + 16'd1;
  endtask

  task automatic pulse(input logic s1, input logic s2);
    Send1 = s1; Send2 = s2;
    step();
    Send1 = 1'b0; Send2 = 1'b0;
  endtask

  // wait for Done, then check pulse counts relative to a snapshot
  task automatic finishMsg(input string nm, input int d0, input int c1_0, input int r1_0,
                           input int c2_0, input int r2_0, input int eC1, input int eR1,
                           input int eC2, input int eR2);
    for (int i = 0; i < 400; i++) begin
      if (doneCnt != d0) break;
      step();
    end
    step(); step();
    chk({nm, "_done"}, doneCnt - d0, 1);
    chk({nm, "_qempty"}, exp.size(), 0);
    chk({nm, "_busy"}, Busy, 0);
    chk({nm, "_clr1"}, cl1 - c1_0, eC1);
    chk({nm, "_rd1"}, rd1 - r1_0, eR1);
    chk({nm, "_clr2"}, cl2 - c2_0, eC2);
    chk({nm, "_rd2"}, rd2 - r2_0, eR2);
  endtask

  typedef struct {
    logic  s1, s2;
    int    sel;
    int    eC1, eR1, eC2, eR2;
    string nm;
  } vec_t;

  initial begin
    vec_t tbl [4];
    int d0, c10, r10, c20, r20, l0;
    tbl[0] = '{1'b1, 1'b0, 1, 1, 2, 0, 0, "send1"};
    tbl[1] = '{1'b0, 1'b1, 2, 0, 0, 1, 0, "send2_seq1"};
    tbl[2] = '{1'b1, 1'b1, 1, 1, 2, 0, 0, "both_msg1_wins"};
    tbl[3] = '{1'b0, 1'b1, 2, 0, 0, 1, 0, "send2_hdr_only"};

    Clear = 1'b1; Send1 = 1'b0; Send2 = 1'b0; TxReady = 1'b1;
    step(); step();
    Clear = 1'b0;
    chk("rst_busy", Busy, 0); chk("rst_done", Done, 0);
    chk("rst_txload", TxLoad, 0); chk("rst_txbyte", TxByte, 0);
    chk("rst_strobes", {ClearMsg1, ClearMsg2, ReadMsg1, ReadMsg2}, 0);

    foreach (tbl[k]) begin
      d0 = doneCnt; c10 = cl1; r10 = rd1; c20 = cl2; r20 = rd2;
      pushMsg(tbl[k].sel);
      pulse(tbl[k].s1, tbl[k].s2);
      chk({tbl[k].nm, "_busy_hi"}, Busy, 1);
      finishMsg(tbl[k].nm, d0, c10, r10, c20, r20,
                tbl[k].eC1, tbl[k].eR1, tbl[k].eC2, tbl[k].eR2);
    end

    // sequence number wrap
    force dut.seqNum = 16'hFFFF;
    step();
    release dut.seqNum;
    seqModel = 16'hFFFF;
    d0 = doneCnt; c10 = cl1; r10 = rd1; c20 = cl2; r20 = rd2;
    pushMsg(2); pulse(1'b0, 1'b1);
    finishMsg("seq_ffff", d0, c10, r10, c20, r20, 0, 0, 1, 0);
    d0 = doneCnt; c10 = cl1; r10 = rd1; c20 = cl2; r20 = rd2;
    pushMsg(1); pulse(1'b1, 1'b0);
    finishMsg("seq_wrap0", d0, c10, r10, c20, r20, 1, 2, 0, 0);

    // TxReady stall before byte 3, with an ignored Send2 mid-message
    d0 = doneCnt; c10 = cl1; r10 = rd1; c20 = cl2; r20 = rd2; l0 = loadCnt;
    pushMsg(1); pulse(1'b1, 1'b0);
    for (int i = 0; i < 100 && loadCnt < l0 + 3; i++) step();
    chk("stall_reach3", loadCnt - l0, 3);
    TxReady = 1'b0;
    for (int i = 0; i < 20; i++) begin
      Send2 = (i == 10);
      step();
    end
    Send2 = 1'b0;
    chk("stall_noload", loadCnt - l0, 3);
    TxReady = 1'b1;
    step();
    chk("stall_resume_load", TxLoad, 1);
    finishMsg("stall", d0, c10, r10, c20, r20, 1, 2, 0, 0);
    l0 = loadCnt;
    repeat (40) step();
    chk("send2_dropped", loadCnt - l0, 0);

    // Clear in the middle of the data bytes
    d0 = doneCnt; l0 = loadCnt;
    pushMsg(1); pulse(1'b1, 1'b0);
    for (int i = 0; i < 100 && loadCnt < l0 + 9; i++) step();
    chk("clr_reach_data", loadCnt - l0, 9);
    Clear = 1'b1;
    exp.delete();
    step();
    Clear = 1'b0;
    chk("clr_busy", Busy, 0);
    chk("clr_outs", {Done, TxLoad, TxByte, ClearMsg1, ClearMsg2, ReadMsg1, ReadMsg2}, 0);
    repeat (30) step();
    chk("clr_noload", loadCnt - l0, 9);
    chk("clr_nodone", doneCnt - d0, 0);
    seqModel = 16'h0;
    d0 = doneCnt; c10 = cl1; r10 = rd1; c20 = cl2; r20 = rd2;
    pushMsg(1); pulse(1'b1, 1'b0);
    finishMsg("after_clr", d0, c10, r10, c20, r20, 1, 2, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
